// File: rtl/hps_uart_pkg.sv
// Shared types and helpers for the HPS loan-IO UART blocks.
package hps_uart_pkg;

  // Start bit + 8 data bits + stop bit.
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/hps_uart_fifo.sv
// Synchronous first-word-fall-through FIFO; dout always shows the head entry.
module hps_uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage write port.
  // NOTE: the data array has no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/hps_uart_tx.sv
// 8N1 UART transmitter with a byte FIFO in front of the serializer.
module hps_uart_tx
  import hps_uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          tx_o,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_bad_div
    $error("hps_uart_tx: CLK_HZ/BAUD gives fewer than 2 cycles per bit");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("hps_uart_tx: FIFO_DEPTH must be a power of two and at least 2");
  end

  uart_state_e   state_q;
  logic [CW-1:0] baud_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shreg_q;
  logic          tx_q;

  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic          bit_end;

  assign bit_end   = (baud_cnt_q == CNT_LAST);
  assign fifo_push = tx_valid && !fifo_full;
  assign tx_ready  = !fifo_full;
  assign tx_o      = tx_q;
  assign busy      = (state_q != IDLE) || (fifo_count != '0);

  hps_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i (wb_clk_i),
    .rst_i (wb_rst_i),
    .push  (fifo_push),
    .din   (tx_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Pop the head when leaving IDLE or at the last cycle of a stop bit.
  // NOTE: defaulting every always_comb output first keeps it free of inferred latches.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      case (state_q)
        IDLE:    fifo_pop = 1'b1;
        STOP:    fifo_pop = bit_end;
        default: fifo_pop = 1'b0;
      endcase
    end
  end

  // Frame sequencer: baud counter, shift register, bit index and registered line.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            shreg_q    <= fifo_dout;
            bit_idx_q  <= '0;
            baud_cnt_q <= '0;
            tx_q       <= 1'b0;
            state_q    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            tx_q       <= shreg_q[0];
            state_q    <= DATA;
          end else begin
            baud_cnt_q <= baud_cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end else begin
              shreg_q   <= {1'b0, shreg_q[7:1]};
              bit_idx_q <= bit_idx_q + 3'd1;
              tx_q      <= shreg_q[1];
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_cnt_q <= '0;
            if (!fifo_empty) begin
              shreg_q   <= fifo_dout;
              bit_idx_q <= '0;
              tx_q      <= 1'b0;
              state_q   <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CW'(1);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hps_uart_tx.sv
// Scoreboard bench for hps_uart_tx at DIV = 10: a line monitor decodes frames
// and checks each against the byte queue filled when the source is accepted.
module tb_hps_uart_tx;
  import hps_uart_pkg::*;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DEPTH  = 16;
  localparam int DIV    = 10;
  localparam int FRAME  = FRAME_BITS * DIV;

  logic       wb_clk_i = 1'b0;
  logic       wb_rst_i = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       tx_o;
  logic       busy;
  logic [4:0] fifo_count;

  hps_uart_tx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_o       (tx_o),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int unsigned cyc = 0;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Reference model: bytes accepted but not yet seen on the line, in order.
  logic [7:0]  exp_q[$];
  int unsigned start_cyc[$];
  int          frames   = 0;
  bit          in_frame = 1'b0;
  bit          have_exp = 1'b0;
  int          k        = 0;
  int          wave_err = 0;
  logic [7:0]  cur_exp  = 8'h00;
  logic [7:0]  decoded  = 8'h00;
  bit          saw_full = 1'b0;

  // Line monitor and occupancy model, sampled on the falling edge.
  always @(negedge wb_clk_i) begin
    bit   active;
    logic expbit;
    if (wb_rst_i) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame && tx_o === 1'b0) begin
        in_frame = 1'b1;
        k        = 0;
        wave_err = 0;
        decoded  = 8'h00;
        start_cyc.push_back(cyc);
        frames++;
        if (exp_q.size() == 0) begin
          have_exp = 1'b0;
          check("unexpected_frame", 32'd1, 32'd0);
        end else begin
          have_exp = 1'b1;
          cur_exp  = exp_q.pop_front();
        end
      end
      active = in_frame;
      if (in_frame) begin
        if (k < DIV)               expbit = 1'b0;
        else if (k >= 9 * DIV)     expbit = 1'b1;
        else                       expbit = cur_exp[(k - DIV) / DIV];
        if (tx_o !== expbit) wave_err++;
        if (k >= DIV && k < 9 * DIV && (k % DIV) == DIV / 2)
          decoded[(k - DIV) / DIV] = tx_o;
        k++;
        if (k == FRAME) begin
          in_frame = 1'b0;
          if (have_exp) begin
            check("frame_wave", 32'(wave_err), 32'd0);
            check("frame_byte", 32'(decoded), 32'(cur_exp));
          end
        end
      end else begin
        check("idle_line", 32'(tx_o), 32'd1);
      end
      check("fifo_count", 32'(fifo_count), 32'(exp_q.size()));
      check("tx_ready", 32'(tx_ready), 32'(exp_q.size() < DEPTH));
      check("busy", 32'(busy), 32'(active || exp_q.size() != 0));
      if (fifo_count == 5'd16 && !tx_ready) saw_full = 1'b1;
    end
  end

  // Present one byte and hold it until accepted; caller is #1 after an edge.
  int unsigned last_acc_cyc = 0;
  task automatic push_byte(input logic [7:0] b);
    int   n;
    logic acc;
    n        = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    do begin
      acc = tx_ready;
      @(posedge wb_clk_i); #1;
      n++;
    end while (!acc && n < 5000);
    tx_valid = 1'b0;
    if (acc) begin
      exp_q.push_back(b);
      last_acc_cyc = cyc;
    end else begin
      check("push_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic wait_drain(input int max_cyc);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || in_frame || busy !== 1'b0) && n < max_cyc) begin
      @(posedge wb_clk_i); #1;
      n++;
    end
    check("drain_timeout", 32'(n < max_cyc), 32'd1);
  endtask

  task automatic wait_frames(input int target, input int max_cyc);
    int n;
    n = 0;
    while (start_cyc.size() < target && n < max_cyc) begin
      @(posedge wb_clk_i); #1;
      n++;
    end
    check("frame_start_timeout", 32'(start_cyc.size() >= target), 32'd1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          base;
    int          sent;
    int          n;
    int unsigned s;
    logic        acc;
    logic [7:0]  b0;

    // Reset and idle line.
    @(posedge wb_clk_i); #1;
    check("rst_tx_o", 32'(tx_o), 32'd1);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_fifo_count", 32'(fifo_count), 32'd0);
    repeat (2) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    repeat (100) @(posedge wb_clk_i);
    #1;

    // Single byte: latency, waveform, busy duration.
    base = start_cyc.size();
    push_byte(8'hA5);
    wait_frames(base + 1, 50);
    if (start_cyc.size() > base) begin
      s = start_cyc[base];
      check("start_latency", 32'(s - last_acc_cyc), 32'd1);
      wait_drain(500);
      check("busy_drop", 32'(cyc - s), 32'(FRAME));
    end

    // Three bytes back to back: contiguous frames.
    base = start_cyc.size();
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h55);
    wait_drain(1000);
    check("b2b_frames", 32'(start_cyc.size() - base), 32'd3);
    if (start_cyc.size() >= base + 3) begin
      check("b2b_gap1", 32'(start_cyc[base + 1] - start_cyc[base]), 32'(FRAME));
      check("b2b_gap2", 32'(start_cyc[base + 2] - start_cyc[base + 1]), 32'(FRAME));
    end

    // Continuous valid with an incrementing source: fill to full, no loss.
    b0       = 8'($urandom_range(0, 255));
    sent     = 0;
    n        = 0;
    saw_full = 1'b0;
    tx_data  = b0;
    tx_valid = 1'b1;
    while (sent < 40 && n < 20000) begin
      acc = tx_ready;
      @(posedge wb_clk_i); #1;
      n++;
      if (acc) begin
        exp_q.push_back(tx_data);
        sent++;
        tx_data = tx_data + 8'd1;
      end
    end
    tx_valid = 1'b0;
    check("burst_sent", 32'(sent), 32'd40);
    check("burst_full_seen", 32'(saw_full), 32'd1);
    wait_drain(6000);

    // Push landing on the same edge as the end-of-stop pop.
    base = start_cyc.size();
    push_byte(8'($urandom_range(0, 255)));
    push_byte(8'($urandom_range(0, 255)));
    wait_frames(base + 1, 50);
    if (start_cyc.size() > base) begin
      s = start_cyc[base];
      n = 0;
      while (cyc < s + FRAME - 1 && n < 200) begin
        @(posedge wb_clk_i); #1;
        n++;
      end
      push_byte(8'($urandom_range(0, 255)));
      check("pushpop_edge", 32'(cyc), 32'(s + FRAME));
      check("pushpop_count", 32'(fifo_count), 32'd1);
    end
    wait_drain(1000);

    // Random bytes with random gaps.
    for (int i = 0; i < 12; i++) begin
      repeat ($urandom_range(0, 150)) @(posedge wb_clk_i);
      #1;
      push_byte(8'($urandom_range(0, 255)));
    end
    wait_drain(3000);

    // Reset mid-DATA with bytes queued: everything discarded.
    base = start_cyc.size();
    for (int i = 0; i < 5; i++) push_byte(8'($urandom_range(0, 255)));
    wait_frames(base + 1, 50);
    if (start_cyc.size() > base) begin
      s = start_cyc[base];
      n = 0;
      while (cyc < s + 35 && n < 200) begin
        @(posedge wb_clk_i); #1;
        n++;
      end
    end
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    wb_rst_i = 1'b0;
    exp_q.delete();
    check("midrst_tx_o", 32'(tx_o), 32'd1);
    check("midrst_fifo_count", 32'(fifo_count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_tx_ready", 32'(tx_ready), 32'd1);
    base = frames;
    repeat (300) @(posedge wb_clk_i);
    #1;
    check("midrst_no_frames", 32'(frames), 32'(base));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
